// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter in front of a FIFO write port. A grant is held until the
// packet ends, BURST_MAX beats are written, or the owner stays idle TIMEOUT cycles.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4,
    parameter int TIMEOUT   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic [2:0]                grant_id,
    output logic                      busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        rr_ptr, rr_ptr_nxt;
    logic [2:0]        grant_nxt;
    logic [2:0]        winner;
    logic              found;
    logic [3:0]        beat_cnt, beat_cnt_nxt;
    logic [7:0]        idle_cnt, idle_cnt_nxt;
    logic              owner_valid;
    logic              owner_last;
    logic [DATA_W-1:0] owner_data;
    logic              beat;

    // Search rr_ptr..NUM_REQ-1 first, then wrap to 0..rr_ptr-1.
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && (3'(i) >= rr_ptr)) begin
                found  = 1'b1;
                winner = 3'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found  = 1'b1;
                winner = 3'(i);
            end
        end
    end

    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 3'(i)) begin
                owner_valid = req_valid[i];
                owner_last  = req_last[i];
                owner_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign beat         = (state == GRANT) && owner_valid && !fifo_full;
    assign fifo_wr_en   = beat;
    assign fifo_wr_data = beat ? owner_data : '0;
    assign busy         = (state == GRANT);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = beat && (grant_id == 3'(i));
        end
    end

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        grant_nxt    = grant_id;
        beat_cnt_nxt = beat_cnt;
        idle_cnt_nxt = idle_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt    = GRANT;
                    grant_nxt    = winner;
                    rr_ptr_nxt   = (winner == 3'(NUM_REQ-1)) ? 3'd0 : winner + 3'd1;
                    beat_cnt_nxt = '0;
                    idle_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (beat) begin
                    // Last beat and burst limit may coincide: one release either way.
                    if (owner_last || (beat_cnt == 4'(BURST_MAX-1))) begin
                        state_nxt    = IDLE;
                        beat_cnt_nxt = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 4'd1;
                    end
                    idle_cnt_nxt = '0;
                end else if (!owner_valid) begin
                    if (idle_cnt == 8'(TIMEOUT-1)) begin
                        state_nxt    = IDLE;
                        beat_cnt_nxt = '0;
                        idle_cnt_nxt = '0;
                    end else begin
                        idle_cnt_nxt = idle_cnt + 8'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking (<=) so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            grant_id <= grant_nxt;
            beat_cnt <= beat_cnt_nxt;
            idle_cnt <= idle_cnt_nxt;
        end
    end

endmodule
